// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder and core:
// default widths, skewer state encoding and the drain-length helper.
package systolic_pkg;

  localparam int DEFAULT_ARRAY_DIM    = 4;
  localparam int DEFAULT_DATA_WIDTH   = 16;
  localparam int DEFAULT_WEIGHT_WIDTH = 8;
  localparam int DEFAULT_ACCUM_WIDTH  = 32;

  typedef enum logic [1:0] {
    SK_IDLE   = 2'd0,
    SK_LOAD_W = 2'd1,
    SK_STREAM = 2'd2,
    SK_DRAIN  = 2'd3
  } skew_state_e;

  // Cycles spent flushing zeros after the last vector so the final
  // result wavefront has left a dim x dim array.
  function automatic int drain_cycles(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register for one activation lane (data + valid).
// Shifts only when enabled; a synchronous clear wipes every stage so a
// new tile never sees leftovers from the previous one.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Stage 0 takes the lane input, later stages take their predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_input_skewer.sv
// Feeder for the weight-stationary systolic core. Captures a weight
// tile, strobes the core's weight load, then skews each accepted
// activation vector so lane r arrives r cycles after lane 0, and
// finally flushes zeros until the last result has left the array.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   SK_IDLE   | waiting for start, all outputs low/zero, lanes held
//   SK_LOAD_W | one cycle, weight-load strobe to the core
//   SK_STREAM | accepting vectors (bubble when no transfer)
//   SK_DRAIN  | injecting zeros, counting down, done on count zero
module systolic_input_skewer
  import systolic_pkg::*;
#(
  parameter int ARRAY_DIM    = DEFAULT_ARRAY_DIM,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic [ARRAY_DIM*ARRAY_DIM*WEIGHT_WIDTH-1:0] weights_in_flat,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0]             in_data_flat,
  input  logic                                        in_last,
  output logic                                        core_enable,
  output logic                                        load_weights_en_array,
  output logic [ARRAY_DIM*ARRAY_DIM*WEIGHT_WIDTH-1:0] core_weights_in_flat,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0]             core_activation_in_flat,
  output logic [ARRAY_DIM-1:0]                        core_act_valid,
  output logic                                        busy,
  output logic                                        done
);

  localparam int W_BITS = ARRAY_DIM * ARRAY_DIM * WEIGHT_WIDTH;
  localparam int CNT_W  = $clog2(2 * ARRAY_DIM);
  // Counter is loaded with one less than the drain length: DRAIN ends
  // in the cycle where the counter reads zero.
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(drain_cycles(ARRAY_DIM) - 1);

  skew_state_e       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [W_BITS-1:0] r_weights;
  logic              r_load_we;
  logic              r_core_en;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;

  logic w_xfer;
  logic w_lane_clr;
  logic w_lane_shift;

  // r_in_ready is high exactly while in SK_STREAM, so it doubles as the
  // handshake qualifier.
  assign w_xfer       = r_in_ready & in_valid;
  assign w_lane_clr   = (r_state == SK_IDLE) & start;
  assign w_lane_shift = (r_state != SK_IDLE);

  // Sequencer with registered outputs; each transition sets the outputs
  // that belong to the destination state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SK_IDLE;
      r_cnt      <= '0;
      r_weights  <= '0;
      r_load_we  <= 1'b0;
      r_core_en  <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        SK_IDLE: begin
          if (start) begin
            r_state   <= SK_LOAD_W;
            r_weights <= weights_in_flat;
            r_load_we <= 1'b1;
            r_core_en <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        SK_LOAD_W: begin
          r_state    <= SK_STREAM;
          r_load_we  <= 1'b0;
          r_in_ready <= 1'b1;
        end
        SK_STREAM: begin
          if (w_xfer && in_last) begin
            r_state    <= SK_DRAIN;
            r_cnt      <= DRAIN_LOAD;
            r_in_ready <= 1'b0;
            r_done     <= (DRAIN_LOAD == '0);
          end
        end
        SK_DRAIN: begin
          if (r_cnt == '0) begin
            // Weights are dropped too so IDLE presents an all-zero face.
            r_state   <= SK_IDLE;
            r_done    <= 1'b0;
            r_core_en <= 1'b0;
            r_busy    <= 1'b0;
            r_weights <= '0;
          end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(1));
          end
        end
        default: begin
          r_state <= SK_IDLE;
        end
      endcase
    end
  end

  assign in_ready              = r_in_ready;
  assign core_enable           = r_core_en;
  assign load_weights_en_array = r_load_we;
  assign core_weights_in_flat  = r_weights;
  assign busy                  = r_busy;
  assign done                  = r_done;

  // Lane r gets r+1 stages; lane 0 is just an output register.
  for (genvar gi = 0; gi < ARRAY_DIM; gi++) begin : g_lane
    logic [DATA_WIDTH:0] w_lane_d;
    logic [DATA_WIDTH:0] w_lane_q;

    assign w_lane_d = w_xfer ? {1'b1, in_data_flat[gi*DATA_WIDTH +: DATA_WIDTH]} : '0;

    skew_delay_line #(
      .DEPTH (gi + 1),
      .WIDTH (DATA_WIDTH + 1)
    ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_lane_shift),
      .i_clr (w_lane_clr),
      .i_d   (w_lane_d),
      .o_q   (w_lane_q)
    );

    assign core_activation_in_flat[gi*DATA_WIDTH +: DATA_WIDTH] = w_lane_q[DATA_WIDTH-1:0];
    assign core_act_valid[gi] = w_lane_q[DATA_WIDTH];
  end

endmodule
